// File: rtl/rv32i_alu_arbiter_pkg.sv
// rtl/rv32i_alu_arbiter_pkg.sv - shared ALU widths, op encodings and response slot states
package rv32i_alu_arbiter_pkg;

    localparam int ALU_OP_WIDTH = 4;
    localparam int XPR_LEN      = 32;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SEQ  = 4'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SNE  = 4'd9;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'd10;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'd11;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 4'd12;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SGE  = 4'd13;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 4'd14;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SGEU = 4'd15;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/rv32i_alu.sv
// rtl/rv32i_alu.sv - RV32I integer ALU; undefined op codes produce zero
module rv32i_alu
    import rv32i_alu_arbiter_pkg::*;
(
    input  logic [ALU_OP_WIDTH-1:0] op,
    input  logic [XPR_LEN-1:0]      in1,
    input  logic [XPR_LEN-1:0]      in2,
    output logic [XPR_LEN-1:0]      out
);

    logic [4:0] shamt;
    assign shamt = in2[4:0];

    always_comb begin
        out = '0;
        case (op)
            ALU_OP_ADD:  out = in1 + in2;
            ALU_OP_SLL:  out = in1 << shamt;
            ALU_OP_XOR:  out = in1 ^ in2;
            ALU_OP_OR:   out = in1 | in2;
            ALU_OP_AND:  out = in1 & in2;
            ALU_OP_SRL:  out = in1 >> shamt;
            ALU_OP_SEQ:  out = {{(XPR_LEN-1){1'b0}}, in1 == in2};
            ALU_OP_SNE:  out = {{(XPR_LEN-1){1'b0}}, in1 != in2};
            ALU_OP_SUB:  out = in1 - in2;
            ALU_OP_SRA:  out = $unsigned($signed(in1) >>> shamt);
            ALU_OP_SLT:  out = {{(XPR_LEN-1){1'b0}}, $signed(in1) < $signed(in2)};
            ALU_OP_SGE:  out = {{(XPR_LEN-1){1'b0}}, $signed(in1) >= $signed(in2)};
            ALU_OP_SLTU: out = {{(XPR_LEN-1){1'b0}}, in1 < in2};
            ALU_OP_SGEU: out = {{(XPR_LEN-1){1'b0}}, in1 >= in2};
            default:     out = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_rr_arbiter.sv
// rtl/rv32i_rr_arbiter.sv - combinational one-hot arbiter, search starts at ptr and wraps upward
module rv32i_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rv32i_alu_arbiter.sv
// rtl/rv32i_alu_arbiter.sv - shares one ALU among NUM_REQ requesters with a one-entry tagged response slot
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module rv32i_alu_arbiter
    import rv32i_alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*ALU_OP_WIDTH-1:0] req_op,
    input  logic [NUM_REQ*XPR_LEN-1:0]      req_in1,
    input  logic [NUM_REQ*XPR_LEN-1:0]      req_in2,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [ID_W-1:0]                 rsp_id,
    output logic [XPR_LEN-1:0]              rsp_data
);

    slot_state_e               state_q, state_d;
    logic [ID_W-1:0]           rsp_id_q, rsp_id_d;
    logic [XPR_LEN-1:0]        rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0]        grant;
    logic [ID_W-1:0]           rr_ptr, gid;
    logic [ALU_OP_WIDTH-1:0]   op_sel;
    logic [XPR_LEN-1:0]        in1_sel, in2_sel, alu_out;
    logic                      slot_free, accept_en, accept;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) rr_ptr_d = (gid == ID_W'(NUM_REQ-1)) ? '0 : gid + ID_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end

    assign rr_ptr = rr_ptr_q;
`endif

    rv32i_rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(ID_W)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign rsp_valid = (state_q == ST_FULL);
    assign slot_free = !rsp_valid || rsp_ready;
    assign accept_en = slot_free && !flush && !reset;
    assign req_ready = grant & {NUM_REQ{accept_en}};
    assign accept    = |(req_valid & req_ready);

    // Grant is one-hot, so AND-OR of the slices selects exactly one requester.
    always_comb begin
        gid     = '0;
        op_sel  = '0;
        in1_sel = '0;
        in2_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gid     = gid     | (ID_W'(i) & {ID_W{grant[i]}});
            op_sel  = op_sel  | (req_op[i*ALU_OP_WIDTH +: ALU_OP_WIDTH] & {ALU_OP_WIDTH{grant[i]}});
            in1_sel = in1_sel | (req_in1[i*XPR_LEN +: XPR_LEN] & {XPR_LEN{grant[i]}});
            in2_sel = in2_sel | (req_in2[i*XPR_LEN +: XPR_LEN] & {XPR_LEN{grant[i]}});
        end
    end

    rv32i_alu u_alu (
        .op  (op_sel),
        .in1 (in1_sel),
        .in2 (in2_sel),
        .out (alu_out)
    );

    always_comb begin
        state_d    = state_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        if (state_q == ST_EMPTY) begin
            if (accept) state_d = ST_FULL;
        end else begin
            if (flush || (rsp_ready && !accept)) state_d = ST_EMPTY;
        end
        if (accept) begin
            rsp_id_d   = gid;
            rsp_data_d = alu_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rsp_id   = rsp_id_q;
    assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_rv32i_alu_arbiter.sv
// tb/tb_rv32i_alu_arbiter.sv - scoreboard bench for rv32i_alu_arbiter with directed vectors
module tb_rv32i_alu_arbiter;
    import rv32i_alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [1:0]  req_valid, req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_in1, req_in2;
    logic        rsp_valid, rsp_ready;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_data;

    rv32i_alu_arbiter #(.NUM_REQ(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:0]  id;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        m_full   = 1'b0;
    logic [31:0] exp_data [2];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops on each response handshake and checks stability under backpressure.
    logic        hold_q = 1'b0;
    logic [31:0] hold_data;
    logic [0:0]  hold_id;

    always @(negedge clk) begin
        if (hold_q && rsp_valid) begin
            chk("hold_data", rsp_data, hold_data);
            chk("hold_id", 32'(rsp_id), 32'(hold_id));
        end
        if (rsp_valid && rsp_ready && !reset) begin
            rsp_t e;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d data %h expected none", rsp_id, rsp_data);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_data", rsp_data, e.data);
            end
        end
        hold_q    = rsp_valid && !rsp_ready && !flush && !reset;
        hold_data = rsp_data;
        hold_id   = rsp_id;
    end

    task automatic set_req(int i, logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] e);
        req_op[i*4 +: 4]    = op;
        req_in1[i*32 +: 32] = a;
        req_in2[i*32 +: 32] = b;
        exp_data[i]         = e;
    endtask

    task automatic step(logic [1:0] exp_ready, string name);
        @(negedge clk);
        chk({name, "_ready"}, 32'(req_ready), 32'(exp_ready));
        chk({name, "_valid"}, 32'(rsp_valid), 32'(m_full));
        if ((reset || flush) && m_full && !rsp_ready) void'(sb_q.pop_front());
        for (int i = 0; i < 2; i++)
            if (exp_ready[i] && req_valid[i]) sb_q.push_back('{id: 1'(i), data: exp_data[i]});
        if (reset || flush)              m_full = 1'b0;
        else if (|(exp_ready & req_valid)) m_full = 1'b1;
        else if (rsp_ready)              m_full = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        req_op = '0; req_in1 = '0; req_in2 = '0;
        exp_data[0] = '0; exp_data[1] = '0;
        @(posedge clk); #1;

        set_req(0, ALU_OP_ADD, 32'd5, 32'd7, 32'd12);
        req_valid = 2'b01;
        step(2'b00, "in_reset");
        reset = 1'b0; rsp_ready = 1'b1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        step(2'b01, "t1_add");
        req_valid = 2'b00;
        step(2'b00, "t1_idle");

        // Round-robin pointer sits at 1 after the first accept.
        set_req(0, ALU_OP_ADD, 32'd1, 32'd1, 32'd2);
        set_req(1, ALU_OP_SUB, 32'd9, 32'd4, 32'd5);
        req_valid = 2'b11;
`ifdef ALU_ARB_FIXED_PRIO_EN
        repeat (4) step(2'b01, "t2_both");
`else
        step(2'b10, "t2_g1");
        step(2'b01, "t2_g0");
        step(2'b10, "t2_g1b");
        step(2'b01, "t2_g0b");
`endif

        req_valid = 2'b01;
        set_req(0, ALU_OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        step(2'b01, "t3_fill");
        rsp_ready = 1'b0; req_valid = 2'b10;
        set_req(1, ALU_OP_ADD, 32'd3, 32'd4, 32'd7);
        repeat (3) step(2'b00, "t3_bp");
        rsp_ready = 1'b1;
        step(2'b10, "t3_release");

        rsp_ready = 1'b0; flush = 1'b1; req_valid = 2'b01;
        set_req(0, ALU_OP_XOR, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F);
        step(2'b00, "t4_flush");
        flush = 1'b0;
        step(2'b01, "t4_after");

        rsp_ready = 1'b1; req_valid = 2'b01;
        set_req(0, ALU_OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
        step(2'b01, "t5_sra");
        rsp_ready = 1'b0; req_valid = 2'b00; reset = 1'b1;
        step(2'b00, "t5_reset");
        reset = 1'b0;
        chk("t5_rst_valid", 32'(rsp_valid), 32'd0);
        chk("t5_rst_id", 32'(rsp_id), 32'd0);
        chk("t5_rst_data", rsp_data, 32'd0);
        rsp_ready = 1'b1; req_valid = 2'b11;
        set_req(0, ALU_OP_OR, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF);
        set_req(1, ALU_OP_AND, 32'h0000_00FF, 32'h0000_000F, 32'h0000_000F);
        step(2'b01, "t5_restart");
`ifdef ALU_ARB_FIXED_PRIO_EN
        step(2'b01, "t5_next");
        repeat (4) step(2'b01, "t6_prio");
`else
        step(2'b10, "t5_next");
        step(2'b01, "t6_rr0");
        step(2'b10, "t6_rr1");
        step(2'b01, "t6_rr0b");
        step(2'b10, "t6_rr1b");
`endif
        req_valid = 2'b10;
        set_req(1, ALU_OP_SLL, 32'h0000_0003, 32'd4, 32'h0000_0030);
        step(2'b10, "t6_only1");

        req_valid = 2'b00;
        step(2'b00, "drain0");
        step(2'b00, "drain1");
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
